mux_select_pipe: RTL and testbench

Parametrised, registered N-way result selector for the 16-bit datapath. Successor to the fixed 4:1 one-bit enable-gated mux used in the ALU result path. It selects one of NUM_INPUTS WIDTH-bit channels, gates it with an enable, and flags out-of-range selects. It registers the result behind a valid/ready handshake so that ALU result selection can be pipelined and back-pressured.

---
 rtl/mux_select_pkg.sv | 27 ++
 rtl/mux_select_pipe_if.sv | 29 ++
 rtl/mux_select_comb.sv | 30 +++
 rtl/mux_select_pipe.sv | 98 +++++++++
 tb/tb_mux_select_pipe.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mux_select_pkg.sv
// Shared types and constant helpers for the registered N-way result selector.
package mux_select_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Captured entry is packed as {data, sel, err}.
  function automatic int entry_w(input int width, input int sel_w);
    return width + sel_w + 1;
  endfunction

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

endpackage

// File: rtl/mux_select_pipe_if.sv
// Request/result handshake bundle for mux_select_pipe.
interface mux_select_pipe_if #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4
);
  import mux_select_pkg::*;
  localparam int SEL_W = clog2(NUM_INPUTS);

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_INPUTS*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]            in_sel;
  logic                        in_en;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [SEL_W-1:0]            out_sel;
  logic                        out_err;

  modport master (
    output in_valid, in_data, in_sel, in_en, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_en, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_err
  );
endinterface

// File: rtl/mux_select_comb.sv
// Combinational channel select with enable gating and out-of-range detection.
module mux_select_comb
  import mux_select_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int NUM_INPUTS = 4,
  localparam int SEL_W      = clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        en,
  output logic [WIDTH-1:0]            res,
  output logic                        err
);

  logic [31:0]      sel_ext;
  logic [WIDTH-1:0] pick;

  always_comb begin
    sel_ext = 32'(sel);
    err     = (sel_ext >= 32'(NUM_INPUTS));
    pick    = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel_ext == 32'(k)) pick = data[k*WIDTH +: WIDTH];
    end
    // Out-of-range selects read as zero even when enabled.
    res = (en && !err) ? pick : '0;
  end

endmodule

// File: rtl/mux_select_pipe.sv
// Registered N-way selector behind valid/ready; define MUX_SELECT_PIPE_SKID_EN
// for a one-entry skid buffer with in_ready driven from registered state.
module mux_select_pipe
  import mux_select_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux_select_pipe_if.slave bus
);

  localparam int SEL_W = clog2(NUM_INPUTS);
  localparam int EW    = entry_w(WIDTH, SEL_W);

  logic [WIDTH-1:0] capt_data;
  logic             capt_err;
  logic [EW-1:0]    capt_e;
  logic [EW-1:0]    out_e;
  occ_e             state, state_nxt;
  logic             acc, deq;
`ifdef MUX_SELECT_PIPE_SKID_EN
  logic [EW-1:0]    skid_e;
`endif

  mux_select_comb #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_comb (
    .data (bus.in_data),
    .sel  (bus.in_sel),
    .en   (bus.in_en),
    .res  (capt_data),
    .err  (capt_err)
  );

  assign capt_e = {capt_data, bus.in_sel, capt_err};
  assign acc    = bus.in_valid && bus.in_ready;
  assign deq    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= OCC_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OCC_EMPTY: if (acc) state_nxt = OCC_FULL;
      OCC_FULL: begin
`ifdef MUX_SELECT_PIPE_SKID_EN
        if (acc && !deq)      state_nxt = OCC_SKID;
        else if (!acc && deq) state_nxt = OCC_EMPTY;
`else
        if (!acc && deq) state_nxt = OCC_EMPTY;
`endif
      end
      OCC_SKID:  if (deq) state_nxt = OCC_FULL;
      default:   state_nxt = OCC_EMPTY;
    endcase
  end

  always_comb begin
    bus.out_valid = (state != OCC_EMPTY);
`ifdef MUX_SELECT_PIPE_SKID_EN
    bus.in_ready  = rst_n && (state != OCC_SKID);
`else
    // Combinational out_ready -> in_ready path: refill on the same edge as drain.
    bus.in_ready  = rst_n && ((state == OCC_EMPTY) || bus.out_ready);
`endif
  end

  // ---- output / skid register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_e  <= '0;
`ifdef MUX_SELECT_PIPE_SKID_EN
      skid_e <= '0;
`endif
    end else begin
`ifdef MUX_SELECT_PIPE_SKID_EN
      if (state == OCC_SKID) begin
        if (deq) out_e <= skid_e;
      end else if (acc && ((state == OCC_EMPTY) || deq)) begin
        out_e <= capt_e;
      end else if (acc) begin
        skid_e <= capt_e;
      end
`else
      if (acc) out_e <= capt_e;
`endif
    end
  end

  assign {bus.out_data, bus.out_sel, bus.out_err} = out_e;

endmodule

// File: tb/tb_mux_select_pipe.sv
// Scoreboard bench for mux_select_pipe: driver pushes expected results, monitor pops and compares.
module tb_mux_select_pipe;
  import mux_select_pkg::*;

  localparam int WIDTH      = 16;
  localparam int NUM_INPUTS = 5;
  localparam int SEL_W      = clog2(NUM_INPUTS);

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_select_pipe_if #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS)) bus ();

  mux_select_pipe #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t             q[$];
  int               checks   = 0;
  int               fails    = 0;
  int               held_now = 0;
  logic [WIDTH-1:0] chan[NUM_INPUTS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int sel, input bit en);
    exp_t e;
    e.sel  = SEL_W'(sel);
    e.err  = (sel >= NUM_INPUTS);
    e.data = '0;
    if (en && !e.err) e.data = chan[sel];
    return e;
  endfunction

  // Monitor: compares the held output against the oldest outstanding request.
  always @(negedge clk) begin
    held_now = q.size();
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (bus.out_valid && q.size() != 0) begin
      check("out_data", 32'(bus.out_data), 32'(q[0].data));
      check("out_sel",  32'(bus.out_sel),  32'(q[0].sel));
      check("out_err",  32'(bus.out_err),  32'(q[0].err));
      if (bus.out_ready) void'(q.pop_front());
    end
  end

  task automatic cycle(input bit rv, input bit v, input int sel, input bit en,
                       input bit ordy, output bit acc);
    bit exp_rdy;
    @(posedge clk);
    #1;
    rst_n         = rv;
    bus.in_valid  = v;
    bus.in_sel    = SEL_W'(sel);
    bus.in_en     = en;
    bus.out_ready = ordy;
    for (int k = 0; k < NUM_INPUTS; k++) bus.in_data[k*WIDTH +: WIDTH] = chan[k];
    @(negedge clk);
    #1;
`ifdef MUX_SELECT_PIPE_SKID_EN
    exp_rdy = rv && (held_now < 2);
`else
    exp_rdy = rv && (held_now == 0 || ordy);
`endif
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = v && rv && bus.in_ready;
    if (!rv)      q.delete();
    else if (acc) q.push_back(model(sel, en));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int idx;
    int exp_n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.in_en     = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) chan[k] = WIDTH'((k + 1) * 16'h1111);

    // Reset held for 3 cycles with out_ready low
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 0, a);
    check("rst out_valid", 32'(bus.out_valid), 0);
    check("rst out_data",  32'(bus.out_data),  0);
    check("rst out_sel",   32'(bus.out_sel),   0);
    check("rst out_err",   32'(bus.out_err),   0);
    check("rst in_ready",  32'(bus.in_ready),  0);
    cycle(1, 0, 0, 0, 0, a);

    // Select sweep, back-to-back
    for (int s = 0; s < 4; s++) cycle(1, 1, s, 1, 1, a);
    // Enable gating, then range errors regardless of enable
    cycle(1, 1, 2, 0, 1, a);
    cycle(1, 1, 6, 1, 1, a);
    cycle(1, 1, 5, 0, 1, a);
    cycle(1, 1, 7, 1, 1, a);
    cycle(1, 1, 4, 1, 1, a);
    cycle(1, 0, 0, 0, 1, a);
    cycle(1, 0, 0, 0, 1, a);

    // Back-pressure: A,B,C offered while out_ready low for 4 cycles
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, idx < 3, idx, 1, 0, a);
      if (a) idx++;
    end
`ifdef MUX_SELECT_PIPE_SKID_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    check("bp accepted during stall", 32'(idx), 32'(exp_n));
    for (int i = 0; i < 8; i++) begin
      cycle(1, idx < 3, idx, 1, 1, a);
      if (a) idx++;
    end
    check("bp all accepted", 32'(idx), 3);

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NUM_INPUTS; k++) chan[k] = WIDTH'($urandom);
      cycle(1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, a);
    end
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1, a);
    check("drain empty", 32'(q.size()), 0);

    // Reset mid-stall with everything held
    for (int k = 0; k < NUM_INPUTS; k++) chan[k] = WIDTH'(16'hA0A0 + k);
    cycle(1, 1, 1, 1, 0, a);
    cycle(1, 1, 2, 1, 0, a);
    cycle(1, 1, 3, 1, 0, a);
    cycle(0, 1, 3, 1, 0, a);
    cycle(1, 0, 0, 0, 0, a);
    check("midrst out_valid", 32'(bus.out_valid), 0);
    check("midrst out_data",  32'(bus.out_data),  0);
    check("midrst out_err",   32'(bus.out_err),   0);
    chan[3] = 16'h5A5A;
    cycle(1, 1, 3, 1, 1, a);
    check("post-rst accept", 32'(a), 1);
    cycle(1, 0, 0, 0, 1, a);
    cycle(1, 0, 0, 0, 1, a);
    check("post-rst drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
